mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single memory port.
//
// Port 0 (c_*) is the CPU, port 1 (d_*) is the debug/loader port. A winning
// request is latched in IDLE, presented to memory for the whole ACCESS phase
// and answered with a one-cycle ack (plus err on timeout) in RESP.
//
// Ports:
//   clk, reset                     clock; synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata/c_wstrb   CPU request and attributes
//   d_req/d_we/d_addr/d_wdata/d_wstrb   debug request and attributes
//   c_ack/d_ack, c_err/d_err       per-port completion pulse and timeout flag
//   rdata                          read data shared by both ports
//   m_en/m_we/m_addr/m_wdata       memory request
//   m_rdata/m_ready                memory response
//   busy                           a transaction is in progress
module mem_arbiter #(
  parameter logic [3:0] TIMEOUT = 4'd15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [3:0]  c_wstrb,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        c_ack,
  output logic        d_ack,
  output logic        c_err,
  output logic        d_err,
  output logic [31:0] rdata,
  output logic        m_en,
  output logic [3:0]  m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;    // port granted most recently
  logic        owner_q, owner_d;  // port of the transaction in flight
  logic        we_q, we_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        win;

  // On a tie the port not granted last wins; otherwise the sole requester.
  assign win = (c_req && d_req) ? ~last_q : d_req;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    we_d    = we_q;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (c_req || d_req) begin
          owner_d = win;
          we_d    = win ? d_we    : c_we;
          wstrb_d = win ? d_wstrb : c_wstrb;
          addr_d  = win ? d_addr  : c_addr;
          wdata_d = win ? d_wdata : c_wdata;
          cnt_d   = 4'd0;
          err_d   = 1'b0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        // m_ready wins over a simultaneous timeout.
        if (m_ready) begin
          err_d   = 1'b0;
          state_d = StResp;
          if (!we_q) begin
            rdata_d = m_rdata;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == TIMEOUT) begin
            err_d   = 1'b1;
            rdata_d = 32'd0;
            state_d = StResp;
          end
        end
      end
      StResp: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      wstrb_q <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    m_en    = (state_q == StAccess);
    m_we    = (m_en && we_q) ? wstrb_q : 4'b0000;
    m_addr  = addr_q;
    m_wdata = wdata_q;
    busy    = (state_q != StIdle);
    c_ack   = (state_q == StResp) && !owner_q;
    d_ack   = (state_q == StResp) && owner_q;
    c_err   = c_ack && err_q;
    d_err   = d_ack && err_q;
    rdata   = rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: table of single transactions with a scoreboard
// of expected completions, plus reset-mid-access and tie sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic [3:0]  c_wstrb = '0;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        c_ack, d_ack, c_err, d_err;
  logic [31:0] rdata;
  logic        m_en;
  logic [3:0]  m_we;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ready = 1'b0;
  logic        busy;

  mem_arbiter #(.TIMEOUT(4'd15)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_wstrb(c_wstrb),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .c_ack(c_ack), .d_ack(d_ack), .c_err(c_err), .d_err(d_err), .rdata(rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;        // ACCESS cycle that raises m_ready; 0 = never
    logic [31:0] mrdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_mwe;
  } vec_t;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  logic resp_window = 1'b0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every ack must fall in an expected RESP cycle and
  // match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (c_ack || d_ack) begin
      check("ack_window", {31'd0, resp_window}, 32'd1);
      check("ack_exclusive", {31'd0, c_ack & d_ack}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL ack_unexpected: got c_ack=%0b d_ack=%0b expected none", c_ack, d_ack);
      end else begin
        mon_e = sb.pop_front();
        check("ack_port", {31'd0, d_ack}, {31'd0, mon_e.port});
        check("ack_rdata", rdata, mon_e.rdata);
        check("ack_err", {31'd0, c_err | d_err}, {31'd0, mon_e.err});
        check("nonowner_err", {31'd0, d_ack ? c_err : d_err}, 32'd0);
      end
    end
  end

  task automatic run_txn(input vec_t v);
    exp_t e;
    int   k;
    bit   done;
    @(posedge clk); #1;
    if (v.port) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wstrb = v.wstrb;
    end else begin
      c_req = 1'b1; c_we = v.we; c_addr = v.addr; c_wdata = v.wdata; c_wstrb = v.wstrb;
    end
    e.port = v.port; e.rdata = v.exp_rdata; e.err = v.exp_err;
    sb.push_back(e);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_m_en", {31'd0, m_en}, 32'd0);
    @(posedge clk); #1;
    // Request latched: drop req and scramble attributes, which must be ignored.
    c_req = 1'b0; c_we = ~v.we; c_addr = ~v.addr; c_wdata = ~v.wdata; c_wstrb = ~v.wstrb;
    d_req = 1'b0; d_we = ~v.we; d_addr = ~v.addr; d_wdata = ~v.wdata; d_wstrb = ~v.wstrb;
    k = 1;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      check("access_m_en", {31'd0, m_en}, 32'd1);
      check("access_m_we", {28'd0, m_we}, {28'd0, v.exp_mwe});
      check("access_m_addr", m_addr, v.addr);
      check("access_m_wdata", m_wdata, v.wdata);
      m_ready = (k == v.lat);
      m_rdata = (k == v.lat) ? v.mrdata : 32'h0BAD0BAD;
      if (k == v.lat || k == 16) done = 1'b1;
      k++;
    end
    @(posedge clk); #1;
    m_ready = 1'b0;
    resp_window = 1'b1;
    @(negedge clk);
    check("resp_ack", {31'd0, c_ack | d_ack}, 32'd1);
    check("resp_m_en", {31'd0, m_en}, 32'd0);
    check("resp_m_we", {28'd0, m_we}, 32'd0);
    check("resp_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    resp_window = 1'b0;
    check("post_busy", {31'd0, busy}, 32'd0);
    check("post_rdata", rdata, v.exp_rdata);
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{port:1'b0, we:1'b0, addr:32'h100, wdata:32'h0, wstrb:4'h0, lat:2,
                mrdata:32'hDEADBEEF, exp_rdata:32'hDEADBEEF, exp_err:1'b0, exp_mwe:4'h0};
    vecs[1] = '{port:1'b1, we:1'b1, addr:32'h200, wdata:32'h00AB0000, wstrb:4'b0100, lat:1,
                mrdata:32'h11111111, exp_rdata:32'hDEADBEEF, exp_err:1'b0, exp_mwe:4'b0100};
    vecs[2] = '{port:1'b0, we:1'b1, addr:32'h204, wdata:32'hCAFEBABE, wstrb:4'b1111, lat:3,
                mrdata:32'h22222222, exp_rdata:32'hDEADBEEF, exp_err:1'b0, exp_mwe:4'b1111};
    vecs[3] = '{port:1'b1, we:1'b0, addr:32'h208, wdata:32'h0, wstrb:4'h0, lat:1,
                mrdata:32'h12345678, exp_rdata:32'h12345678, exp_err:1'b0, exp_mwe:4'h0};
    vecs[4] = '{port:1'b0, we:1'b0, addr:32'h20C, wdata:32'h0, wstrb:4'h0, lat:0,
                mrdata:32'h33333333, exp_rdata:32'h0, exp_err:1'b1, exp_mwe:4'h0};
    vecs[5] = '{port:1'b1, we:1'b0, addr:32'h210, wdata:32'h0, wstrb:4'h0, lat:16,
                mrdata:32'hCAFEF00D, exp_rdata:32'hCAFEF00D, exp_err:1'b0, exp_mwe:4'h0};
    vecs[6] = '{port:1'b0, we:1'b1, addr:32'h214, wdata:32'h0000EE00, wstrb:4'b0010, lat:0,
                mrdata:32'h44444444, exp_rdata:32'h0, exp_err:1'b1, exp_mwe:4'b0010};
    vecs[7] = '{port:1'b0, we:1'b0, addr:32'h218, wdata:32'h0, wstrb:4'h0, lat:5,
                mrdata:32'hA5A5A5A5, exp_rdata:32'hA5A5A5A5, exp_err:1'b0, exp_mwe:4'h0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_m_en", {31'd0, m_en}, 32'd0);
    check("rst_m_we", {28'd0, m_we}, 32'd0);
    check("rst_acks", {30'd0, c_ack, d_ack}, 32'd0);
    check("rst_errs", {30'd0, c_err, d_err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_m_wdata", m_wdata, 32'd0);

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Reset during the 2nd ACCESS cycle of a CPU read; last grant was port 0.
    @(posedge clk); #1;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h300;
    @(posedge clk); #1;
    c_req = 1'b0;
    @(posedge clk); #1;
    check("mid_m_en", {31'd0, m_en}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_m_en", {31'd0, m_en}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    check("abort_m_addr", m_addr, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Tie with both requests held and memory always ready: 0,1,0,1.
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    m_ready = 1'b1; m_rdata = 32'h55AA55AA;
    resp_window = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e.port = i[0]; e.rdata = 32'h55AA55AA; e.err = 1'b0;
      sb.push_back(e);
    end
    repeat (12) @(posedge clk);
    #1;
    c_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
    resp_window = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("tie_idle_busy", {31'd0, busy}, 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

endmodule
